// File: rtl/ppu_video_pkg.sv
// Shared constants and helpers for the PPU display path.
// Holds default 640x480@60 raster timing and RGB565/RGB888 field widths.
// rgb565_to_888 widens each channel by replicating its top bits into the new LSBs.
package ppu_video_pkg;

  // Default 640x480@60 timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Colour field widths
  localparam int R5_W   = 5;
  localparam int G6_W   = 6;
  localparam int B5_W   = 5;
  localparam int CH8_W  = 8;
  localparam int RGB565_W = R5_W + G6_W + B5_W;
  localparam int RGB888_W = 3 * CH8_W;

  // Bit replication keeps full-scale codes full scale (1F -> FF, 3F -> FF).
  function automatic logic [RGB888_W-1:0] rgb565_to_888(input logic [RGB565_W-1:0] p);
    logic [R5_W-1:0] r;
    logic [G6_W-1:0] g;
    logic [B5_W-1:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r, r[R5_W-1:R5_W-3], g, g[G6_W-1:G6_W-2], b, b[B5_W-1:B5_W-3]};
  endfunction

endpackage

// File: rtl/ppu_delay_line.sv
// Fixed-depth register delay line for the raster control bundle.
// Latency: DEPTH clocks (DEPTH = 0 is a plain wire).
// No backpressure: shifts every clock; reset loads RESET_VAL into every stage.
module ppu_delay_line
  import ppu_video_pkg::*;
#(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rstn;
      assign unused_clk_rstn = clk ^ rstn;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one stage per clock; reset fills all stages with the idle value
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ppu_video_timing_gen.sv
// Raster timing generator + pixel pipeline: fetch coords, latency-matched sync/de, RGB565->RGB888.
// Latency: RD_LATENCY+1 clocks from pixel_req to video_de/hs/vs of the same raster position.
// No backpressure: free-running at pixel rate; optional PPU_VTG_SCANLINE_EN halves odd-line game pixels.
module ppu_video_timing_gen
  import ppu_video_pkg::*;
#(
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          H_FP       = DEF_H_FP,
  parameter int          H_SYNC     = DEF_H_SYNC,
  parameter int          H_BP       = DEF_H_BP,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter int          V_FP       = DEF_V_FP,
  parameter int          V_SYNC     = DEF_V_SYNC,
  parameter int          V_BP       = DEF_V_BP,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int          RD_LATENCY = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter int          COORD_W    = 12
) (
  input  logic               hdmi_clk,
  input  logic               rstn,
  output logic [COORD_W-1:0] pixel_xpos,
  output logic [COORD_W-1:0] pixel_ypos,
  output logic               pixel_req,
  input  logic [15:0]        rd_data,
  input  logic               IsGameWindow,
  output logic               video_hs,
  output logic               video_vs,
  output logic               video_de,
  output logic [23:0]        video_rgb,
  output logic               frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;

`ifdef PPU_VTG_SCANLINE_EN
  localparam int BW = 5;   // hs, vs, active, first pixel, y parity
`else
  localparam int BW = 4;   // hs, vs, active, first pixel
`endif
  // Idle bundle: syncs inactive, no de, so nothing glitches while the pipe fills after reset
  localparam logic [BW-1:0] IDLE_BUNDLE = {~HS_POL, ~VS_POL, {(BW-2){1'b0}}};

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_act;
  logic               v_act;
  logic               active;
  logic               hs_raw;
  logic               vs_raw;
  logic               first_px;
  logic [COORD_W-1:0] x_raw;
  logic [COORD_W-1:0] y_raw;
  logic [BW-1:0]      bundle_in;
  logic [BW-1:0]      bundle_out;
  logic               hs_d;
  logic               vs_d;
  logic               act_d;
  logic               first_d;
  logic [23:0]        pix_rgb;
  logic [23:0]        rgb_next;

  // Raster counters: h wraps every line, v advances on each h wrap
  always_ff @(posedge hdmi_clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == COORD_W'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      if (v_cnt == COORD_W'(V_TOTAL - 1)) v_cnt <= '0;
      else                                v_cnt <= v_cnt + COORD_W'(1);
    end else begin
      h_cnt <= h_cnt + COORD_W'(1);
    end
  end

  // Stage S0: decode windows, syncs and fetch coordinates straight from the counters
  always_comb begin
    h_act      = (h_cnt >= COORD_W'(H_START)) && (h_cnt < COORD_W'(H_END));
    v_act      = (v_cnt >= COORD_W'(V_START)) && (v_cnt < COORD_W'(V_END));
    active     = h_act && v_act;
    x_raw      = h_cnt - COORD_W'(H_START);
    y_raw      = v_cnt - COORD_W'(V_START);
    pixel_req  = active;
    pixel_xpos = active ? x_raw : '0;
    pixel_ypos = active ? y_raw : '0;
    hs_raw     = (h_cnt < COORD_W'(H_SYNC)) ? HS_POL : ~HS_POL;
    vs_raw     = (v_cnt < COORD_W'(V_SYNC)) ? VS_POL : ~VS_POL;
    first_px   = active && (x_raw == '0) && (y_raw == '0);
  end

`ifdef PPU_VTG_SCANLINE_EN
  logic yodd_d;
  assign bundle_in = {hs_raw, vs_raw, active, first_px, pixel_ypos[0]};
  assign {hs_d, vs_d, act_d, first_d, yodd_d} = bundle_out;
`else
  assign bundle_in = {hs_raw, vs_raw, active, first_px};
  assign {hs_d, vs_d, act_d, first_d} = bundle_out;
`endif

  // Align control with the frame-buffer read return
  ppu_delay_line #(
    .DEPTH     (RD_LATENCY),
    .WIDTH     (BW),
    .RESET_VAL (IDLE_BUNDLE)
  ) u_ctrl_dly (
    .clk  (hdmi_clk),
    .rstn (rstn),
    .d    (bundle_in),
    .q    (bundle_out)
  );

  // Stage SD: choose game pixel, border or blank black
  always_comb begin
    pix_rgb = rgb565_to_888(rd_data);
`ifdef PPU_VTG_SCANLINE_EN
    if (yodd_d) pix_rgb = {1'b0, pix_rgb[23:17], 1'b0, pix_rgb[15:9], 1'b0, pix_rgb[7:1]};
`endif
    rgb_next = 24'h0;
    if (act_d) rgb_next = IsGameWindow ? pix_rgb : BORDER_RGB;
  end

  // Output register feeding the DVI transmitter
  always_ff @(posedge hdmi_clk or negedge rstn) begin
    if (!rstn) begin
      video_hs    <= ~HS_POL;
      video_vs    <= ~VS_POL;
      video_de    <= 1'b0;
      video_rgb   <= 24'h0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= hs_d;
      video_vs    <= vs_d;
      video_de    <= act_d;
      video_rgb   <= rgb_next;
      frame_start <= first_d;
    end
  end

endmodule

// File: tb/tb_ppu_video_timing_gen.sv
// Bench for ppu_video_timing_gen: small-raster instance with RD_LATENCY=3 plus a default 640x480 instance.
// Scoreboard queues expected pixels at pixel_req and pops them at video_de.
// Default build (scanline feature undefined).
module tb_ppu_video_timing_gen;

  localparam int A_HA = 16, A_HFP = 2, A_HS = 4, A_HBP = 3;
  localparam int A_VA = 6,  A_VFP = 1, A_VS = 2, A_VBP = 2;
  localparam int A_HT = A_HS + A_HBP + A_HA + A_HFP;
  localparam int A_VT = A_VS + A_VBP + A_VA + A_VFP;
  localparam int A_HST = A_HS + A_HBP;
  localparam int A_VST = A_VS + A_VBP;
  localparam int A_LAT = 3;
  localparam logic [23:0] A_BORDER = 24'h202020;

  typedef struct packed {logic hs; logic vs; logic de;} sync_t;
  typedef struct {logic [23:0] rgb; logic fs; int due;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, rstn_b;
  logic [11:0] xa, ya, xb, yb;
  logic        req_a, req_b, gw_a, gw_b;
  logic [15:0] rd_a, rd_b;
  logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
  logic [23:0] rgb_a, rgb_b;

  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  ppu_video_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LATENCY(A_LAT),
    .BORDER_RGB(A_BORDER), .COORD_W(12)
  ) dut_a (
    .hdmi_clk(clk), .rstn(rstn_a), .pixel_xpos(xa), .pixel_ypos(ya), .pixel_req(req_a),
    .rd_data(rd_a), .IsGameWindow(gw_a), .video_hs(hs_a), .video_vs(vs_a),
    .video_de(de_a), .video_rgb(rgb_a), .frame_start(fs_a)
  );

  ppu_video_timing_gen dut_b (
    .hdmi_clk(clk), .rstn(rstn_b), .pixel_xpos(xb), .pixel_ypos(yb), .pixel_req(req_b),
    .rd_data(rd_b), .IsGameWindow(gw_b), .video_hs(hs_b), .video_vs(vs_b),
    .video_de(de_b), .video_rgb(rgb_b), .frame_start(fs_b)
  );

  function automatic logic [23:0] exp_rgb(input logic [15:0] p);
    logic [7:0] r, g, b;
    r = {p[15:11], 3'b000} | {5'b00000, p[15:13]};
    g = {p[10:5], 2'b00}   | {6'b000000, p[10:9]};
    b = {p[4:0], 3'b000}   | {5'b00000, p[4:2]};
    return {r, g, b};
  endfunction

  function automatic logic [15:0] pix_of(input int x, input int y);
    case (x)
      0:       return 16'hF800;
      1:       return 16'hFFFF;
      2:       return 16'h0000;
      3:       return 16'h07E0;
      default: return 16'(x * 733 + y * 4099 + 12345);
    endcase
  endfunction

  function automatic logic gw_of(input int x, input int y);
    return (x != 4) && (y != 5);
  endfunction

  task automatic test_reset();
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_a !== 1'b0)  begin fails++; $display("FAIL rst_req_a: got %b expected 0", req_a); end
    checks++; if (xa !== 12'd0)    begin fails++; $display("FAIL rst_x_a: got %0d expected 0", xa); end
    checks++; if (ya !== 12'd0)    begin fails++; $display("FAIL rst_y_a: got %0d expected 0", ya); end
    checks++; if (hs_a !== 1'b1)   begin fails++; $display("FAIL rst_hs_a: got %b expected 1", hs_a); end
    checks++; if (vs_a !== 1'b1)   begin fails++; $display("FAIL rst_vs_a: got %b expected 1", vs_a); end
    checks++; if (de_a !== 1'b0)   begin fails++; $display("FAIL rst_de_a: got %b expected 0", de_a); end
    checks++; if (rgb_a !== 24'h0) begin fails++; $display("FAIL rst_rgb_a: got %h expected 000000", rgb_a); end
    checks++; if (fs_a !== 1'b0)   begin fails++; $display("FAIL rst_fs_a: got %b expected 0", fs_a); end
    checks++; if (req_b !== 1'b0)  begin fails++; $display("FAIL rst_req_b: got %b expected 0", req_b); end
    checks++; if (hs_b !== 1'b1)   begin fails++; $display("FAIL rst_hs_b: got %b expected 1", hs_b); end
    checks++; if (vs_b !== 1'b1)   begin fails++; $display("FAIL rst_vs_b: got %b expected 1", vs_b); end
    checks++; if (rgb_b !== 24'h0) begin fails++; $display("FAIL rst_rgb_b: got %h expected 000000", rgb_b); end
  endtask

  // Three frames of the small raster: coordinates, sync/de alignment, pixel scoreboard, frame counts
  task automatic test_stream();
    sync_t dly[4];
    int    hx[A_LAT], hy[A_LAT];
    bit    hv[A_LAT];
    int    mh, mv, mx, my, nde, nhs, nvs, nfs;
    bit    mreq, fs_seen;
    exp_t  e;
    rstn_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    for (int i = 0; i < A_LAT; i++) begin hv[i] = 1'b0; hx[i] = 0; hy[i] = 0; end
    dly[0] = '{hs: 1'b0, vs: 1'b0, de: 1'b0};
    for (int i = 1; i < 4; i++) dly[i] = '{hs: 1'b1, vs: 1'b1, de: 1'b0};
    mh = 0; mv = 0; nde = 0; nhs = 0; nvs = 0; nfs = 0; fs_seen = 1'b0;
    rstn_a = 1'b1;
    for (int n = 1; n <= 3 * A_HT * A_VT; n++) begin
      @(negedge clk);
      mh++;
      if (mh == A_HT) begin mh = 0; mv++; if (mv == A_VT) mv = 0; end
      mreq = (mh >= A_HST) && (mh < A_HST + A_HA) && (mv >= A_VST) && (mv < A_VST + A_VA);
      mx = mreq ? mh - A_HST : 0;
      my = mreq ? mv - A_VST : 0;
      checks++; if (req_a !== mreq)   begin fails++; $display("FAIL req n=%0d: got %b expected %b", n, req_a, mreq); end
      checks++; if (xa !== 12'(mx))   begin fails++; $display("FAIL xpos n=%0d: got %0d expected %0d", n, xa, mx); end
      checks++; if (ya !== 12'(my))   begin fails++; $display("FAIL ypos n=%0d: got %0d expected %0d", n, ya, my); end
      checks++; if (hs_a !== dly[3].hs) begin fails++; $display("FAIL hs n=%0d: got %b expected %b", n, hs_a, dly[3].hs); end
      checks++; if (vs_a !== dly[3].vs) begin fails++; $display("FAIL vs n=%0d: got %b expected %b", n, vs_a, dly[3].vs); end
      checks++; if (de_a !== dly[3].de) begin fails++; $display("FAIL de n=%0d: got %b expected %b", n, de_a, dly[3].de); end
      if (de_a === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL sb_empty n=%0d: de with no pending pixel", n);
        end else begin
          e = sb.pop_front();
          checks++; if (e.due != n) begin fails++; $display("FAIL latency: de at %0d expected %0d", n, e.due); end
          checks++; if (rgb_a !== e.rgb) begin fails++; $display("FAIL rgb n=%0d: got %h expected %h", n, rgb_a, e.rgb); end
          checks++; if (fs_a !== e.fs) begin fails++; $display("FAIL fs n=%0d: got %b expected %b", n, fs_a, e.fs); end
        end
      end else begin
        checks++; if (rgb_a !== 24'h0) begin fails++; $display("FAIL blank_rgb n=%0d: got %h expected 000000", n, rgb_a); end
        checks++; if (fs_a !== 1'b0) begin fails++; $display("FAIL fs_blank n=%0d: got %b expected 0", n, fs_a); end
        if (sb.size() > 0) begin
          checks++;
          if (sb[0].due <= n) begin
            fails++; $display("FAIL missing_de n=%0d: got none expected pixel due %0d", n, sb[0].due);
            void'(sb.pop_front());
          end
        end
      end
      if (fs_a === 1'b1) begin
        nfs++;
        if (fs_seen) begin
          checks++; if (nde != A_HA * A_VA) begin fails++; $display("FAIL de_per_frame: got %0d expected %0d", nde, A_HA * A_VA); end
          checks++; if (nhs != A_HS * A_VT) begin fails++; $display("FAIL hs_low_per_frame: got %0d expected %0d", nhs, A_HS * A_VT); end
          checks++; if (nvs != A_VS * A_HT) begin fails++; $display("FAIL vs_low_per_frame: got %0d expected %0d", nvs, A_VS * A_HT); end
        end
        fs_seen = 1'b1; nde = 0; nhs = 0; nvs = 0;
      end
      nde += int'(de_a === 1'b1);
      nhs += int'(hs_a === 1'b0);
      nvs += int'(vs_a === 1'b0);
      if (mreq) begin
        e.rgb = gw_of(mx, my) ? exp_rgb(pix_of(mx, my)) : A_BORDER;
        e.fs  = (mx == 0) && (my == 0);
        e.due = n + A_LAT + 1;
        sb.push_back(e);
      end
      if (hv[A_LAT-1]) begin
        rd_a = pix_of(hx[A_LAT-1], hy[A_LAT-1]);
        gw_a = gw_of(hx[A_LAT-1], hy[A_LAT-1]);
      end else begin
        rd_a = 16'($urandom);
        gw_a = 1'($urandom);
      end
      for (int i = A_LAT - 1; i > 0; i--) begin hv[i] = hv[i-1]; hx[i] = hx[i-1]; hy[i] = hy[i-1]; end
      hv[0] = mreq; hx[0] = mx; hy[0] = my;
      for (int i = 3; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = '{hs: (mh >= A_HS), vs: (mv >= A_VS), de: mreq};
    end
    checks++; if (nfs != 3) begin fails++; $display("FAIL frame_count: got %0d expected 3", nfs); end
  endtask

  // Async reset in the middle of active video, then restart timing and glitch-free sync fill
  task automatic test_async_reset_mid_active();
    int n;
    bit got;
    for (int i = 0; i < 400 && de_a !== 1'b1; i++) @(negedge clk);
    checks++; if (de_a !== 1'b1) begin fails++; $display("FAIL wait_de_a: got %b expected 1", de_a); end
    #2 rstn_a = 1'b0;
    #1;
    checks++; if (req_a !== 1'b0)  begin fails++; $display("FAIL arst_req: got %b expected 0", req_a); end
    checks++; if (xa !== 12'd0)    begin fails++; $display("FAIL arst_x: got %0d expected 0", xa); end
    checks++; if (de_a !== 1'b0)   begin fails++; $display("FAIL arst_de: got %b expected 0", de_a); end
    checks++; if (rgb_a !== 24'h0) begin fails++; $display("FAIL arst_rgb: got %h expected 000000", rgb_a); end
    checks++; if (hs_a !== 1'b1)   begin fails++; $display("FAIL arst_hs: got %b expected 1", hs_a); end
    @(negedge clk);
    @(negedge clk);
    rstn_a = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (n <= A_LAT) begin
        checks++; if (hs_a !== 1'b1) begin fails++; $display("FAIL hs_fill n=%0d: got %b expected 1", n, hs_a); end
      end else if (n == A_LAT + 1) begin
        checks++; if (hs_a !== 1'b0) begin fails++; $display("FAIL hs_first_sync: got %b expected 0", hs_a); end
      end
      if (req_a === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != A_HST + A_VST * A_HT) begin
      fails++; $display("FAIL first_req_a: got %0d clocks expected %0d", n, A_HST + A_VST * A_HT);
    end
  endtask

  // Default 640x480 instance: reset during sync, restart latency, 565->888 and border select
  task automatic test_default_restart();
    int n;
    rd_b = 16'hF800;
    gw_b = 1'b1;
    @(negedge clk);
    rstn_b = 1'b1;
    repeat (850) @(posedge clk);
    #3;
    checks++; if (hs_b !== 1'b0) begin fails++; $display("FAIL pre_hs_b: got %b expected 0", hs_b); end
    checks++; if (vs_b !== 1'b0) begin fails++; $display("FAIL pre_vs_b: got %b expected 0", vs_b); end
    rstn_b = 1'b0;
    #1;
    checks++; if (hs_b !== 1'b1)   begin fails++; $display("FAIL arst_hs_b: got %b expected 1", hs_b); end
    checks++; if (vs_b !== 1'b1)   begin fails++; $display("FAIL arst_vs_b: got %b expected 1", vs_b); end
    checks++; if (de_b !== 1'b0)   begin fails++; $display("FAIL arst_de_b: got %b expected 0", de_b); end
    checks++; if (fs_b !== 1'b0)   begin fails++; $display("FAIL arst_fs_b: got %b expected 0", fs_b); end
    @(negedge clk);
    @(negedge clk);
    rstn_b = 1'b1;
    n = 0;
    while (req_b !== 1'b1 && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n != 144 + 35 * 800) begin fails++; $display("FAIL first_req_b: got %0d clocks expected %0d", n, 144 + 35 * 800); end
    checks++; if (xb !== 12'd0 || yb !== 12'd0) begin fails++; $display("FAIL first_xy_b: got %0d,%0d expected 0,0", xb, yb); end
    n = 0;
    while (de_b !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n != 2) begin fails++; $display("FAIL de_latency_b: got %0d expected 2", n); end
    checks++; if (rgb_b !== 24'hFF0000) begin fails++; $display("FAIL red_b: got %h expected ff0000", rgb_b); end
    checks++; if (fs_b !== 1'b1) begin fails++; $display("FAIL fs_b: got %b expected 1", fs_b); end
    gw_b = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rgb_b !== 24'h000000) begin fails++; $display("FAIL border_b: got %h expected 000000", rgb_b); end
    checks++; if (fs_b !== 1'b0) begin fails++; $display("FAIL fs_once_b: got %b expected 0", fs_b); end
    gw_b = 1'b1;
    rd_b = 16'h07E0;
    @(posedge clk);
    #1;
    checks++; if (rgb_b !== 24'h00FF00) begin fails++; $display("FAIL green_b: got %h expected 00ff00", rgb_b); end
  endtask

  initial begin
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    rd_a = 16'h0;
    gw_a = 1'b0;
    rd_b = 16'h0;
    gw_b = 1'b0;
    test_reset();
    test_stream();
    test_async_reset_mid_active();
    test_default_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
